alu_muldiv_seq: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle integer ALU. Executes the RV32M-class multiply/divide operations over a WIDTH-bit datapath.
- Uses a radix-2 shift-add / restoring-division engine.
- Sits beside the combinational ALU in the execute stage and stalls the core through a valid/ready handshake.
- Adds capabilities the single-cycle ALU lacks: parametric width, sequential operation, handshake, abort, and RISC-V divide-by-zero and overflow semantics.

---
 rtl/alu_muldiv_seq.sv | 189 ++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - sequential RV32M-class multiply/divide unit
//
// Radix-2 shift-add multiplier and restoring divider that share one
// 2*WIDTH-bit working register. Requests and results use valid/ready
// handshakes. Divide-by-zero and signed overflow are resolved at accept.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_valid / o_ready         request handshake (i_op, i_operand_a, i_operand_b)
//   o_valid / i_ready         result handshake (o_result)
//   i_flush                   abort the in-flight operation
//   o_busy                    high whenever the FSM is not IDLE
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [2:0]       OP_MULH   = 3'b001;
    localparam logic [2:0]       OP_MULHSU = 3'b010;
    localparam logic [2:0]       OP_DIV    = 3'b100;
    localparam logic [2:0]       OP_REM    = 3'b110;
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q;
    logic [2:0]         op_q;
    logic               neg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   opnd_q;      // |a| (multiplicand) or |b| (divisor)
    logic [2*WIDTH-1:0] prod_q;      // mul: {acc, multiplier}; div: {rem, dividend/quotient}
    logic [WIDTH-1:0]   result_q;
    logic               ready_q;
    logic               valid_q;
    logic               busy_q;

    // Accept-time decode
    logic               sgn_a;
    logic               sgn_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               div_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   special_res;

    // Iteration and fix-up datapath
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] step_d;
    logic [2*WIDTH-1:0] mul_p;
    logic [WIDTH-1:0]   div_sel;
    logic [WIDTH-1:0]   fix_res;

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        if (i_op == OP_MULH || i_op == OP_MULHSU || i_op == OP_DIV || i_op == OP_REM)
            sgn_a = i_operand_a[WIDTH-1];
        if (i_op == OP_MULH || i_op == OP_DIV || i_op == OP_REM)
            sgn_b = i_operand_b[WIDTH-1];
        mag_a = sgn_a ? -i_operand_a : i_operand_a;
        mag_b = sgn_b ? -i_operand_b : i_operand_b;

        div_zero = i_op[2] && (i_operand_b == '0);
        div_ovf  = (i_op == OP_DIV || i_op == OP_REM) &&
                   (i_operand_a == MOST_NEG) && (i_operand_b == '1);
        special_res = '0;
        if (div_zero)
            special_res = i_op[1] ? i_operand_a : '1;
        else if (div_ovf)
            special_res = i_op[1] ? '0 : i_operand_a;
    end

    always_comb begin
        // Multiply: add multiplicand to the upper half when the LSB is set, shift right.
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        // Divide: shift the dividend MSB into the remainder, subtract if it fits.
        div_trial = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opnd_q};
        if (op_q[2])
            step_d = {(div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                      prod_q[WIDTH-2:0], ~div_diff[WIDTH]};
        else
            step_d = {mul_sum, prod_q[WIDTH-1:1]};

        mul_p   = neg_q ? -prod_q : prod_q;
        div_sel = op_q[1] ? prod_q[2*WIDTH-1:WIDTH] : prod_q[WIDTH-1:0];
        if (op_q[2])
            fix_res = neg_q ? -div_sel : div_sel;
        else if (op_q[1:0] == 2'b00)
            fix_res = mul_p[WIDTH-1:0];
        else
            fix_res = mul_p[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            prod_q   <= '0;
            result_q <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A flush in IDLE suppresses a simultaneous request.
                    if (i_valid && !i_flush) begin
                        op_q    <= i_op;
                        neg_q   <= (i_op == OP_REM) ? sgn_a : (sgn_a ^ sgn_b);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            valid_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            opnd_q  <= i_op[2] ? mag_b : mag_a;
                            prod_q  <= {{WIDTH{1'b0}}, (i_op[2] ? mag_a : mag_b)};
                            cnt_q   <= CNT_W'(WIDTH);
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (i_flush) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        prod_q <= step_d;
                        cnt_q  <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1))
                            state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (i_flush) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        result_q <= fix_res;
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_flush || i_ready) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_busy   = busy_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - self-checking bench for alu_muldiv_seq
module tb_alu_muldiv_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          out_ready;
    logic [2:0]    op;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic          flush;
    logic          out_valid;
    logic          in_ready;
    logic [W-1:0]  result;
    logic          busy;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] sb[$];

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_valid     (in_valid),
        .o_ready     (out_ready),
        .i_op        (op),
        .i_operand_a (opa),
        .i_operand_b (opb),
        .i_flush     (flush),
        .o_valid     (out_valid),
        .i_ready     (in_ready),
        .o_result    (result),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sbv, ub, ps;
        logic [63:0] pu;
        sa  = {{32{a[W-1]}}, a};
        sbv = {{32{b[W-1]}}, b};
        ub  = {32'b0, b};
        case (o)
            3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
            3'd1: begin ps = sa * sbv; return ps[63:32]; end
            3'd2: begin ps = sa * ub;  return ps[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == '1) return a;
                ps = sa / sbv; return ps[31:0];
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == '1) return '0;
                ps = sa % sbv; return ps[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        return o[2] && (b == 0 || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == '1));
    endfunction

    // Issue one request, wait for the result, check latency and value, leave DONE unacknowledged.
    task automatic issue_and_wait(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] exp, input string tag);
        int lat;
        int exp_lat;
        exp_lat = is_special(o, a, b) ? 1 : W + 2;
        sb.push_back(exp);
        @(negedge clk);
        chk({tag, "_ready_before"}, W'(out_ready), W'(1));
        in_valid = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        opa = $urandom; opb = $urandom; op = 3'($urandom);
        chk({tag, "_ready_after"}, W'(out_ready), W'(0));
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, W'(lat), W'(exp_lat));
        if (sb.size() > 0) chk({tag, "_result"}, result, sb.pop_front());
        else chk({tag, "_scoreboard_empty"}, W'(0), W'(1));
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        in_ready = 1'b1;
        @(posedge clk); #1;
        in_ready = 1'b0;
        chk({tag, "_ack_valid"}, W'(out_valid), W'(0));
        chk({tag, "_ack_ready"}, W'(out_ready), W'(1));
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input string tag);
        issue_and_wait(o, a, b, exp, tag);
        ack(tag);
    endtask

    initial begin
        logic [W-1:0] held;
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;

        rst = 1'b1; in_valid = 1'b0; op = '0; opa = '0; opb = '0; flush = 1'b0; in_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready",  W'(out_ready), W'(1));
        chk("reset_valid",  W'(out_valid), W'(0));
        chk("reset_busy",   W'(busy),      W'(0));
        chk("reset_result", result,        W'(0));
        @(negedge clk); rst = 1'b0;

        run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2");
        run_op(3'd5, 32'd100,       32'd7,         32'd14,        "divu_100_7");
        run_op(3'd7, 32'd100,       32'd7,         32'd2,         "remu_100_7");
        run_op(3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, "div_by0");
        run_op(3'd6, 32'd5,         32'd0,         32'd5,         "rem_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf");

        for (int i = 0; i < 8; i++) begin
            ro = 3'(i);
            ra = $urandom;
            rb = (i == 5) ? 32'd3 : $urandom;
            run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rand%0d", i));
        end

        // Hold the result for 10 cycles with i_ready low.
        issue_and_wait(3'd1, 32'h1234_5678, 32'hFEDC_BA98, model(3'd1, 32'h1234_5678, 32'hFEDC_BA98), "hold");
        held = result;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("hold_valid%0d", i),  W'(out_valid), W'(1));
            chk($sformatf("hold_result%0d", i), result,        held);
        end
        ack("hold");
        run_op(3'd5, 32'd1000, 32'd10, 32'd100, "after_hold");

        // Flush during CALC iteration 5.
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; opa = 32'd3; opb = 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_valid", W'(out_valid), W'(0));
        chk("flush_ready", W'(out_ready), W'(1));
        chk("flush_busy",  W'(busy),      W'(0));
        begin
            int seen = 0;
            for (int i = 0; i < W + 4; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            chk("flush_no_result", W'(seen), W'(0));
        end

        // Flush in IDLE blocks a simultaneous request.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; op = 3'd0; opa = 32'd2; opb = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_ready", W'(out_ready), W'(1));
        chk("idle_flush_busy",  W'(busy),      W'(0));

        // Reset in the middle of CALC.
        @(negedge clk);
        in_valid = 1'b1; op = 3'd5; opa = 32'd77; opb = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid",  W'(out_valid), W'(0));
        chk("rst_mid_ready",  W'(out_ready), W'(1));
        chk("rst_mid_result", result,        W'(0));
        chk("rst_mid_busy",   W'(busy),      W'(0));
        @(negedge clk); rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < W + 4; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            chk("rst_no_result", W'(seen), W'(0));
        end

        run_op(3'd7, 32'd77, 32'd5, 32'd2, "after_reset");
        chk("scoreboard_drained", W'(sb.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
